shift_left_sequential: RTL and testbench



---
 rtl/shift_left_sequential.sv | 122 ++++++++++++
 tb/tb_shift_left_sequential.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/shift_left_sequential.sv
// shift_left_sequential: multi-cycle left shifter that moves at most STEP bits per cycle over valid/ready handshakes
//
// Parameters:
//   WIDTH        data width in bits (>= 2)
//   AMOUNT_WIDTH width of the shift amount input (>= 1)
//   STEP         maximum bits shifted per cycle (1..WIDTH)
//   PAD_VALUE    bit inserted into vacated LSBs
//
// Ports:
//   clock        system clock, rising edge
//   reset        synchronous active-high reset; aborts any transaction in flight
//   input_valid  input transaction valid
//   input_ready  high in IDLE while reset is low
//   input_data   word to shift
//   input_amount unsigned left-shift amount, saturated to WIDTH
//   output_valid result valid (OUTPUT state)
//   output_ready consumer accepts the result
//   output_data  shifted result, always driven from the data register
//   busy         high whenever the FSM is not IDLE
//   carry_out    last bit shifted out of the MSB, present only when
//                SHIFT_LEFT_SEQUENTIAL_CARRY_OUT_EN is defined
module shift_left_sequential #(
    parameter int   WIDTH        = 8,
    parameter int   AMOUNT_WIDTH = 4,
    parameter int   STEP         = 1,
    parameter logic PAD_VALUE    = 1'b0
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    input_valid,
    output logic                    input_ready,
    input  logic [WIDTH-1:0]        input_data,
    input  logic [AMOUNT_WIDTH-1:0] input_amount,
    output logic                    output_valid,
    input  logic                    output_ready,
    output logic [WIDTH-1:0]        output_data,
    output logic                    busy
`ifdef SHIFT_LEFT_SEQUENTIAL_CARRY_OUT_EN
    ,
    output logic                    carry_out
`endif
);
    localparam int RW = $clog2(WIDTH + 1);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SHIFT  = 2'd1;
    localparam logic [1:0] OUTPUT = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] data;
    logic [RW-1:0]    remaining;
    logic [RW-1:0]    step_n;
    logic [RW-1:0]    rem_next;
    logic [RW-1:0]    amount_sat;
    logic             amount_over;
    logic [WIDTH-1:0] pad_mask;
    logic [WIDTH-1:0] shifted;

    // Saturating the amount at WIDTH bounds latency; anything beyond that is all-pad anyway
    always_comb begin
        amount_over = 32'(input_amount) > 32'(WIDTH);
        amount_sat  = amount_over ? RW'(WIDTH) : RW'(input_amount);
        step_n      = (32'(remaining) < 32'(STEP)) ? remaining : RW'(STEP);
        rem_next    = remaining - step_n;
        pad_mask    = ~({WIDTH{1'b1}} << step_n);
        shifted     = (data << step_n) | (PAD_VALUE ? pad_mask : '0);
    end

    assign input_ready  = (state == IDLE) && !reset;
    assign output_valid = (state == OUTPUT);
    assign output_data  = data;
    assign busy         = (state != IDLE);

`ifdef SHIFT_LEFT_SEQUENTIAL_CARRY_OUT_EN
    logic carry;
    logic over;
    logic last_bit;
    // The lowest of the n bits leaving the MSB this cycle is the last one out
    assign last_bit  = |(data & (WIDTH'(1) << (WIDTH - int'(step_n))));
    assign carry_out = carry;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            data      <= '0;
            remaining <= '0;
`ifdef SHIFT_LEFT_SEQUENTIAL_CARRY_OUT_EN
            carry     <= 1'b0;
            over      <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (input_valid) begin
                        data      <= input_data;
                        remaining <= amount_sat;
                        state     <= (amount_sat == '0) ? OUTPUT : SHIFT;
`ifdef SHIFT_LEFT_SEQUENTIAL_CARRY_OUT_EN
                        carry     <= 1'b0;
                        over      <= amount_over;
`endif
                    end
                end
                SHIFT: begin
                    data      <= shifted;
                    remaining <= rem_next;
                    if (rem_next == '0)
                        state <= OUTPUT;
`ifdef SHIFT_LEFT_SEQUENTIAL_CARRY_OUT_EN
                    // Past WIDTH only pad bits would have left the MSB last
                    carry <= (rem_next == '0 && over) ? PAD_VALUE : last_bit;
`endif
                end
                OUTPUT: begin
                    if (output_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_shift_left_sequential.sv
// tb_shift_left_sequential: randomized and directed check of shift_left_sequential against an arithmetic reference model
module tb_shift_left_sequential;
    localparam int STEPS[3] = '{1, 3, 1};
    localparam logic PADS[3] = '{1'b0, 1'b0, 1'b1};

    logic       clock;
    logic       reset;
    logic       iv[3];
    logic       ir[3];
    logic [7:0] id[3];
    logic [3:0] ia[3];
    logic       ov[3];
    logic       orr[3];
    logic [7:0] od[3];
    logic       bz[3];
`ifdef SHIFT_LEFT_SEQUENTIAL_CARRY_OUT_EN
    logic       co[3];
`endif
    int vectors;
    int miscompares;

    shift_left_sequential #(.WIDTH(8), .AMOUNT_WIDTH(4), .STEP(1), .PAD_VALUE(1'b0)) dut0 (
        .clock(clock), .reset(reset), .input_valid(iv[0]), .input_ready(ir[0]),
        .input_data(id[0]), .input_amount(ia[0]), .output_valid(ov[0]),
        .output_ready(orr[0]), .output_data(od[0]), .busy(bz[0])
`ifdef SHIFT_LEFT_SEQUENTIAL_CARRY_OUT_EN
        , .carry_out(co[0])
`endif
    );
    shift_left_sequential #(.WIDTH(8), .AMOUNT_WIDTH(4), .STEP(3), .PAD_VALUE(1'b0)) dut1 (
        .clock(clock), .reset(reset), .input_valid(iv[1]), .input_ready(ir[1]),
        .input_data(id[1]), .input_amount(ia[1]), .output_valid(ov[1]),
        .output_ready(orr[1]), .output_data(od[1]), .busy(bz[1])
`ifdef SHIFT_LEFT_SEQUENTIAL_CARRY_OUT_EN
        , .carry_out(co[1])
`endif
    );
    shift_left_sequential #(.WIDTH(8), .AMOUNT_WIDTH(4), .STEP(1), .PAD_VALUE(1'b1)) dut2 (
        .clock(clock), .reset(reset), .input_valid(iv[2]), .input_ready(ir[2]),
        .input_data(id[2]), .input_amount(ia[2]), .output_valid(ov[2]),
        .output_ready(orr[2]), .output_data(od[2]), .busy(bz[2])
`ifdef SHIFT_LEFT_SEQUENTIAL_CARRY_OUT_EN
        , .carry_out(co[2])
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Concatenate the word with a byte of pad, shift the 16-bit value, keep the top byte
    function automatic logic [7:0] model_data(logic [7:0] d, int a, logic pad);
        logic [15:0] full;
        int s;
        s = (a > 8) ? 8 : a;
        full = {d, {8{pad}}};
        full = full << s;
        return full[15:8];
    endfunction

    function automatic logic model_carry(logic [7:0] d, int a, logic pad);
        if (a == 0) return 1'b0;
        if (a <= 8) return d[8 - a];
        return pad;
    endfunction

    function automatic int model_latency(int a, int step);
        int s;
        s = (a > 8) ? 8 : a;
        return 1 + (s + step - 1) / step;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Presents one word just after an edge, waits for the result, optionally
    // stalls the consumer, then completes the output handshake.
    task automatic xact(input int k, input logic [7:0] d, input int a, input int hold,
                        input bit keep, input logic [7:0] nd, input int na);
        int n;
        logic [7:0] exp_d;
        exp_d = model_data(d, a, PADS[k]);
        iv[k] = 1'b1;
        id[k] = d;
        ia[k] = 4'(a);
        chk("input_ready_idle", 32'(ir[k]), 1);
        n = 0;
        do begin
            @(posedge clock); #1;
            n++;
            if (n == 1) begin
                if (keep) begin
                    id[k] = nd;
                    ia[k] = 4'(na);
                end else
                    iv[k] = 1'b0;
                chk("busy_after_accept", 32'(bz[k]), 1);
            end
        end while (!ov[k] && n < 40);
        chk("latency", 32'(n), 32'(model_latency(a, STEPS[k])));
        chk("output_data", 32'(od[k]), 32'(exp_d));
`ifdef SHIFT_LEFT_SEQUENTIAL_CARRY_OUT_EN
        chk("carry_out", 32'(co[k]), 32'(model_carry(d, a, PADS[k])));
`endif
        for (int i = 0; i < hold; i++) begin
            @(posedge clock); #1;
            chk("stall_valid", 32'(ov[k]), 1);
            chk("stall_data", 32'(od[k]), 32'(exp_d));
            chk("stall_input_ready", 32'(ir[k]), 0);
        end
        orr[k] = 1'b1;
        @(posedge clock); #1;
        orr[k] = 1'b0;
        chk("valid_after_handshake", 32'(ov[k]), 0);
        chk("ready_after_handshake", 32'(ir[k]), 1);
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            iv[k] = 1'b0;
            id[k] = '0;
            ia[k] = '0;
            orr[k] = 1'b0;
        end
        repeat (2) @(posedge clock);
        #1;
        chk("reset_input_ready", 32'(ir[0]), 0);
        chk("reset_output_valid", 32'(ov[0]), 0);
        chk("reset_output_data", 32'(od[0]), 0);
        chk("reset_busy", 32'(bz[0]), 0);
        reset = 1'b0;
        @(posedge clock); #1;

        xact(0, 8'hB5, 3, 0, 1'b0, 8'h00, 0);
        xact(0, 8'h5A, 0, 0, 1'b0, 8'h00, 0);
        xact(0, 8'h5A, 8, 0, 1'b0, 8'h00, 0);
        xact(0, 8'hC7, 15, 0, 1'b0, 8'h00, 0);
        xact(1, 8'hFF, 7, 0, 1'b0, 8'h00, 0);
        xact(2, 8'h0F, 2, 0, 1'b0, 8'h00, 0);

        xact(0, 8'h3C, 2, 5, 1'b1, 8'h81, 1);
        xact(0, 8'h81, 1, 0, 1'b0, 8'h00, 0);

        iv[0] = 1'b1;
        id[0] = 8'hC3;
        ia[0] = 4'd6;
        @(posedge clock); #1;
        iv[0] = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk("mid_shift_busy", 32'(bz[0]), 1);
        reset = 1'b1;
        @(posedge clock); #1;
        chk("abort_output_valid", 32'(ov[0]), 0);
        chk("abort_output_data", 32'(od[0]), 0);
        chk("abort_busy", 32'(bz[0]), 0);
        chk("abort_input_ready", 32'(ir[0]), 0);
        reset = 1'b0;
        #1;
        chk("abort_ready_release", 32'(ir[0]), 1);
        for (int i = 0; i < 8; i++) begin
            @(posedge clock); #1;
            chk("abort_no_output", 32'(ov[0]), 0);
        end
        xact(0, 8'h01, 1, 0, 1'b0, 8'h00, 0);

        for (int r = 0; r < 25; r++)
            for (int k = 0; k < 3; k++)
                xact(k, 8'($urandom), int'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
                     1'b0, 8'h00, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
